// File: rtl/ext_domain_pkg.sv
// rtl/ext_domain_pkg.sv - shared state encoding and default timing constants for external power domains
// ST_ERR exists only when EXT_DOMAIN_TIMEOUT_EN is defined.
package ext_domain_pkg;

    localparam int DEF_RST_CYCLES  = 4;
    localparam int DEF_ACK_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_PWR_UP  = 3'd1,
        ST_RST_REL = 3'd2,
        ST_ON      = 3'd3,
        ST_PWR_DN  = 3'd4
`ifdef EXT_DOMAIN_TIMEOUT_EN
        ,
        ST_ERR     = 3'd5
`endif
    } dom_state_e;

endpackage

// File: rtl/ext_domain_fsm.sv
// rtl/ext_domain_fsm.sv - one domain: ack synchroniser, sequencing FSM, reset-release and ack-timeout counters
// Ack timeout and ERR state are built only with EXT_DOMAIN_TIMEOUT_EN.
module ext_domain_fsm
    import ext_domain_pkg::*;
#(
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_pwr_req,
    input  logic i_err_clr,
    input  logic i_switch_ack,
    input  logic i_dom_int,
    output logic o_switch,
    output logic o_iso,
    output logic o_rst_n,
    output logic o_clk_en,
    output logic o_on,
    output logic o_err,
    output logic o_intr
);

    localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(ACK_TIMEOUT - 1);

    dom_state_e r_state;
    dom_state_e w_state_nxt;
    logic       r_ack_meta;
    logic       r_ack_s;
    logic [7:0] r_rst_cnt;
    logic       w_timeout;

`ifdef EXT_DOMAIN_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    assign w_timeout = (r_to_cnt == TO_LAST);
`else
    logic w_unused;
    assign w_timeout = 1'b0;
    assign w_unused  = i_err_clr ^ (^TO_LAST);
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF:     if (i_pwr_req) w_state_nxt = ST_PWR_UP;
            ST_PWR_UP: begin
                if (!i_pwr_req)     w_state_nxt = ST_PWR_DN;
                else if (r_ack_s)   w_state_nxt = ST_RST_REL;
`ifdef EXT_DOMAIN_TIMEOUT_EN
                else if (w_timeout) w_state_nxt = ST_ERR;
`endif
            end
            ST_RST_REL: begin
                if (!i_pwr_req)                  w_state_nxt = ST_PWR_DN;
                else if (r_rst_cnt == RST_LAST)  w_state_nxt = ST_ON;
            end
            ST_ON:      if (!i_pwr_req) w_state_nxt = ST_PWR_DN;
            ST_PWR_DN: begin
                if (!r_ack_s)       w_state_nxt = ST_OFF;
`ifdef EXT_DOMAIN_TIMEOUT_EN
                else if (w_timeout) w_state_nxt = ST_ERR;
            end
            ST_ERR: begin
                if (i_err_clr && !i_pwr_req) w_state_nxt = ST_OFF;
`endif
            end
            default:    w_state_nxt = ST_OFF;
        endcase
    end

    // Outputs decode the next state so they flip on the same edge the state register does.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_OFF;
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
            r_rst_cnt  <= '0;
`ifdef EXT_DOMAIN_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
            o_switch   <= 1'b0;
            o_iso      <= 1'b1;
            o_rst_n    <= 1'b0;
            o_clk_en   <= 1'b0;
            o_on       <= 1'b0;
            o_err      <= 1'b0;
            o_intr     <= 1'b0;
        end else begin
            r_ack_meta <= i_switch_ack;
            r_ack_s    <= r_ack_meta;
            r_state    <= w_state_nxt;
            r_rst_cnt  <= (r_state == ST_RST_REL) ? r_rst_cnt + 8'd1 : 8'd0;
`ifdef EXT_DOMAIN_TIMEOUT_EN
            if (w_state_nxt != r_state)
                r_to_cnt <= '0;
            else if (r_state == ST_PWR_UP || r_state == ST_PWR_DN)
                r_to_cnt <= r_to_cnt + 16'd1;
            o_err      <= (w_state_nxt == ST_ERR);
`else
            o_err      <= 1'b0;
`endif
            o_switch   <= (w_state_nxt inside {ST_PWR_UP, ST_RST_REL, ST_ON});
            o_iso      <= !(w_state_nxt inside {ST_RST_REL, ST_ON});
            o_clk_en   <= (w_state_nxt inside {ST_RST_REL, ST_ON});
            o_rst_n    <= (w_state_nxt == ST_ON);
            o_on       <= (w_state_nxt == ST_ON);
            o_intr     <= i_dom_int && (w_state_nxt == ST_ON);
        end
    end

endmodule

// File: rtl/ext_domain_ctrl.sv
// rtl/ext_domain_ctrl.sv - external power-domain controller, one ext_domain_fsm per domain plus interrupt vector
// Optional ack timeout / ERR state enabled by EXT_DOMAIN_TIMEOUT_EN.
module ext_domain_ctrl
    import ext_domain_pkg::*;
#(
    parameter int N_DOMAINS   = 1,
    parameter int NEXT_INT    = 16,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_DOMAINS-1:0] pwr_req_i,
    input  logic [N_DOMAINS-1:0] err_clr_i,
    input  logic [N_DOMAINS-1:0] switch_ack_i,
    input  logic [N_DOMAINS-1:0] dom_int_i,
    output logic [N_DOMAINS-1:0] switch_o,
    output logic [N_DOMAINS-1:0] iso_o,
    output logic [N_DOMAINS-1:0] rst_no,
    output logic [N_DOMAINS-1:0] clk_en_o,
    output logic [N_DOMAINS-1:0] on_o,
    output logic [N_DOMAINS-1:0] err_o,
    output logic [NEXT_INT-1:0]  intr_vector_o
);

    logic [N_DOMAINS-1:0] w_intr;

    for (genvar d = 0; d < N_DOMAINS; d++) begin : g_dom
        ext_domain_fsm #(
            .RST_CYCLES  (RST_CYCLES),
            .ACK_TIMEOUT (ACK_TIMEOUT)
        ) u_fsm (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .i_pwr_req    (pwr_req_i[d]),
            .i_err_clr    (err_clr_i[d]),
            .i_switch_ack (switch_ack_i[d]),
            .i_dom_int    (dom_int_i[d]),
            .o_switch     (switch_o[d]),
            .o_iso        (iso_o[d]),
            .o_rst_n      (rst_no[d]),
            .o_clk_en     (clk_en_o[d]),
            .o_on         (on_o[d]),
            .o_err        (err_o[d]),
            .o_intr       (w_intr[d])
        );
    end

    always_comb begin
        intr_vector_o                = '0;
        intr_vector_o[N_DOMAINS-1:0] = w_intr;
    end

endmodule
